// File: rtl/dmem_responder.sv
// Word-organised data memory with byte-enabled stores behind a req/gnt/rvalid
// handshake, with a fixed number of wait states between grant and response.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        gnt,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept, commit;
  logic          c_we, c_err;
  logic [31:0]   c_addr, c_wdata;
  logic [3:0]    c_be;
  logic [AW-1:0] c_idx;

  // With zero wait states the commit happens on the grant edge, so the live
  // inputs are used; otherwise the attributes latched at grant are used.
  always_comb begin
    accept  = (state_q == S_IDLE) && req;
    c_we    = (state_q == S_IDLE) ? we    : we_q;
    c_addr  = (state_q == S_IDLE) ? addr  : addr_q;
    c_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
    c_be    = (state_q == S_IDLE) ? be    : be_q;
    c_idx   = c_addr[AW+1:2];
    c_err   = (c_addr[1:0] != 2'b00) ||
              ({2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    commit  = 1'b0;
    rdata_d = '0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt = req;
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      err_d = c_err;
      if (!c_we && !c_err) rdata_d = mem_q[c_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (commit && c_we && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (c_be[b]) mem_q[c_idx][b*8 +: 8] <= c_wdata[b*8 +: 8];
      end
    end
  end

  assign rvalid = (state_q == S_RESP);
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and one
// with zero wait states, sharing clock and reset.
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic        gnt0, rvalid0, err0;
  logic [31:0] rdata0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .err(err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0),
    .wdata(wdata0), .be(be0), .gnt(gnt0), .rvalid(rvalid0), .rdata(rdata0),
    .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the block idle; returns at the falling edge
  // of the cycle after the response, where the next request may be driven.
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b,
                     input logic [31:0] exp_rd, input logic exp_err);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    #1 check({tag, ".gnt"}, 32'(gnt), 32'd1);
    @(posedge clk); #1;
    req = 1'b0; we = ~w; addr = ~a; wdata = ~d; be = ~b;
    for (int i = 0; i <= W; i++) begin
      @(negedge clk);
      check({tag, ".rvalid"}, 32'(rvalid), (i == W) ? 32'd1 : 32'd0);
      if (i == W) begin
        check({tag, ".rdata"}, rdata, exp_rd);
        check({tag, ".err"}, 32'(err), 32'(exp_err));
      end
    end
    @(negedge clk);
    check({tag, ".rvalid_off"}, 32'(rvalid), 32'd0);
    check({tag, ".rdata_off"}, rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    #2;
    check("rst.rvalid", 32'(rvalid), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.gnt", 32'(gnt), 32'd0);
    @(negedge clk); #2;
    reset = 1'b1;
    @(negedge clk);

    txn("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
    txn("st20", 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    txn("ld20a", 1'b0, 32'h20, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    txn("st20be", 1'b1, 32'h20, 32'h11223344, 4'b0101, 32'h0, 1'b0);
    txn("ld20b", 1'b0, 32'h20, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    txn("st20nop", 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    txn("ld20c", 1'b0, 32'h20, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);

    txn("st00", 1'b1, 32'h0, 32'h12345678, 4'hF, 32'h0, 1'b0);
    txn("ld22mis", 1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1);
    txn("st400oor", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    txn("ld00", 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0);

    // req held high: a grant only every W+2 cycles
    req = 1'b1; we = 1'b0; addr = 32'h20; wdata = '0; be = '0;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("hold.gnt", 32'(gnt), (i % 4 == 0) ? 32'd1 : 32'd0);
      check("hold.rvalid", 32'(rvalid), (i % 4 == 3) ? 32'd1 : 32'd0);
      if (i % 4 == 3) check("hold.rdata", rdata, 32'hDE22BE44);
      @(negedge clk);
    end
    req = 1'b0;
    @(negedge clk);

    // zero wait states: response in the cycle after grant, no grant in RESP
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h0BADF00D; be0 = 4'hF;
    #1 check("w0.st.gnt", 32'(gnt0), 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check("w0.st.rvalid", 32'(rvalid0), 32'd1);
    check("w0.st.err", 32'(err0), 32'd0);
    check("w0.st.rdata", rdata0, 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
    #1 check("w0.resp.gnt", 32'(gnt0), 32'd0);
    @(negedge clk);
    check("w0.ld.rvalid_pre", 32'(rvalid0), 32'd0);
    check("w0.ld.gnt", 32'(gnt0), 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check("w0.ld.rvalid", 32'(rvalid0), 32'd1);
    check("w0.ld.rdata", rdata0, 32'h0BADF00D);
    @(negedge clk);

    // reset during a response clears outputs at once
    req = 1'b1; we = 1'b0; addr = 32'h20;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (W + 1) @(negedge clk);
    check("rresp.rvalid", 32'(rvalid), 32'd1);
    check("rresp.rdata", rdata, 32'hDE22BE44);
    #2 reset = 1'b0;
    #1;
    check("rresp.rvalid0", 32'(rvalid), 32'd0);
    check("rresp.rdata0", rdata, 32'd0);
    check("rresp.err0", 32'(err), 32'd0);
    #2 reset = 1'b1;
    @(negedge clk);

    // reset during WAIT of a store discards it
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; be = 4'hF;
    #1 check("rwait.gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rwait.rvalid", 32'(rvalid), 32'd0);
    check("rwait.rdata", rdata, 32'd0);
    check("rwait.err", 32'(err), 32'd0);
    #2 reset = 1'b1;
    @(negedge clk);
    txn("ld30", 1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0);
    txn("ld20clr", 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the processor's data-memory load/store interface.
- Word-organised RAM with byte enables, behind a req/gnt/rvalid handshake.
- Fixed, parameterised wait-state latency, so multi-cycle memory timing can be modelled.
- Sits between a load/store initiator and the storage array; replaces the zero-latency data memory in multi-cycle and pipelined builds.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; byte address range is 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2, wait states between grant and response; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; block is in reset while low.
- req  input  1  initiator request; held with its attributes until gnt is seen.
- we  input  1  1 = store, 0 = load.
- addr  input  32  byte address; must be word-aligned.
- wdata  input  32  store data.
- be  input  4  byte enables for stores; be[i] selects wdata[8i+7:8i]; ignored for loads.
- gnt  output  1  request accepted this cycle; combinational, equals req while in IDLE.
- rvalid  output  1  one-cycle response strobe.
- rdata  output  32  load data, valid while rvalid is high; 0 for stores and errors.
- err  output  1  response error flag, valid while rvalid is high.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE; counter = 0.
  - rvalid = 0, rdata = 0, err = 0.
  - All memory words cleared to 0.
  - An in-flight transaction is aborted; a store not yet committed is discarded.
- States: IDLE, WAIT, RESP.
- IDLE:
  - gnt = req.
  - On req: latch addr, we, wdata, be.
  - Go to RESP if WAIT_CYCLES = 0; otherwise go to WAIT with cnt = WAIT_CYCLES.
- WAIT:
  - gnt = 0; cnt decrements each cycle.
  - When cnt = 1, go to RESP.
  - WAIT therefore lasts exactly WAIT_CYCLES cycles.
- Commit (on the clock edge entering RESP):
  - Error check: err = (addr[1:0] != 0) OR (addr[31:2] >= DEPTH_WORDS).
  - Store without error: write only the bytes enabled by be; be = 0 is a legal no-op.
  - Load without error: rdata <= mem[addr[31:2]].
  - Any error: memory is untouched and rdata <= 0.
- RESP:
  - rvalid = 1 for exactly one cycle; gnt = 0.
  - req in this cycle is ignored (not granted).
  - Next state is IDLE, and rvalid, err and rdata return to 0.
- Latency: a request granted in cycle T gives rvalid in cycle T+1+WAIT_CYCLES.
  - Maximum throughput is one transaction per WAIT_CYCLES+2 cycles.
- Ordering: a store's commit is visible to every later load, including a load issued in the cycle right after the store's RESP.
- Inputs are sampled only at grant; changes to addr, wdata, be or we after grant have no effect.
- Reset deasserted mid-cycle: the first grant is possible on the first rising edge after release.

Test Plan:
- Reset then load 0x00000010 with WAIT_CYCLES=2: gnt in cycle T, rvalid only in T+3, rdata=0x00000000, err=0.
- Store 0xDEADBEEF to 0x20 with be=4'b1111, then load 0x20: second rvalid shows rdata=0xDEADBEEF, err=0.
- Store 0x11223344 to 0x20 with be=4'b0101 over existing 0xDEADBEEF, then load 0x20: rdata=0xDE22BE44.
- Load from 0x22 (misaligned), store to 0x400 (out of range for DEPTH_WORDS=256):
  - Both give err=1 and rdata=0.
  - A following load of 0x0 returns the unchanged value.
- req held high continuously: gnt pulses every 4 cycles (WAIT_CYCLES=2); no grant in WAIT or RESP.
- WAIT_CYCLES=0: rvalid in cycle T+1.
- Reset asserted low during WAIT of a store to 0x30:
  - rvalid, err and rdata go to 0 immediately.
  - After release, a load of 0x30 returns 0.
